gnr_attractor_ctrl: RTL and testbench
=====================================

// Module: gnr_attractor_ctrl
// PURPOSE
//  Sequences a GNR node array (nodes with reset_nos/start_s0/start_s1, slow s0 and fast s1 copies).
//  Per accepted initial state: loads the array, runs Floyd tortoise/hare search until s0==s1,
//  then measures the attractor period. Sits between the host init-state stream and the node array.
// PARAMETERS
//  N_NODES    188   number of network nodes; width of state vectors
//  CNT_W      32    width of step and period counters
//  MAX_STEPS  2**20 step budget for FIND+PERIOD (used only with GNR_TIMEOUT_EN)
// PORTS
//  clk            in   1        clock; all logic on posedge
//  rst            in   1        asynchronous, active-high reset
//  init_valid     in   1        initial state offered
//  init_ready     out  1        controller can accept an initial state
//  init_data      in   N_NODES  initial network state
//  reset_nos      out  1        load pulse to all nodes
//  init_state     out  N_NODES  per-node load value, valid while reset_nos=1
//  start_s0       out  1        advance slow copy (nodes step s0 every 2nd pulse)
//  start_s1       out  1        advance fast copy (one step per pulse)
//  net_s0         in   N_NODES  concatenated node s0 outputs
//  net_s1         in   N_NODES  concatenated node s1 outputs
//  res_valid      out  1        result available
//  res_ready      in   1        result consumed
//  res_detect     out  CNT_W    step count k at which s0==s1 was found
//  res_period     out  CNT_W    attractor period (steps)
//  res_state      out  N_NODES  net_s1 captured at end of PERIOD (state on the attractor)
//  res_timeout    out  1        search aborted on budget (0 without GNR_TIMEOUT_EN)
//  busy           out  1        state != IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE; every output 0 except init_ready=1. Async rst aborts any phase immediately.
//  IDLE: init_ready=1; on init_valid&&init_ready latch init_data -> LOAD.
//  LOAD (1 cycle): reset_nos=1, init_state=latched data, steps=0 -> FIND.
//  FIND: steps = start pulses issued since LOAD; net_* reflect that count each cycle.
//   if steps even && steps>=2 && net_s0==net_s1: no start this cycle, res_detect<=steps -> PERIOD.
//   else start_s0=start_s1=1, steps++. Invariant: s0 = step ceil(k/2), s1 = step k.
//  PERIOD: per=0; start_s0=0 (s0 frozen). if per>=1 && net_s1==net_s0: res_period<=per,
//   res_state<=net_s1 -> DONE; else start_s1=1, per++.
//  DONE: res_valid=1, results stable until res_valid&&res_ready -> IDLE (init_ready=1 next cycle).
//  start_s0/start_s1/reset_nos never asserted outside LOAD/FIND/PERIOD; never together with reset_nos.
//  Compare is combinational on registered node outputs; decision and pulses in same cycle.
//  Counters saturate at 2**CNT_W-1 (no wrap). Without timeout, search runs until match.
// CONFIGURATION
//  GNR_TIMEOUT_EN defined: total pulses (steps+per) reaching MAX_STEPS ends search -> DONE with
//   res_timeout=1, res_period=0, res_detect=steps at abort, res_state=net_s1.
//  GNR_TIMEOUT_EN undefined: no budget logic; res_timeout tied 0; MAX_STEPS ignored.
// STRUCTURE
//  gnr_ctrl_pkg: FSM state enum (IDLE, LOAD, FIND, PERIOD, DONE), CNT_W default, counter
//   saturation helper function.
//  Sub-module gnr_state_cmp: N_NODES-wide equality of net_s0/net_s1 (isolated for wide N).
// TESTING (bench uses N_NODES=4 behavioural node model)
//  1 Identity network, init 4'b0000 -> res_detect=2, res_period=1, res_state=4'b0000.
//  2 Rotate-left ring, init 4'b0001 -> res_detect=8, res_period=4, res_timeout=0.
//  3 res_ready=0 for 10 cycles in DONE -> res_valid held, all res_* stable, init_ready=0.
//  4 rst at FIND step 5 -> outputs 0 same cycle, start_* low; after release init_ready=1, new run correct.
//  5 GNR_TIMEOUT_EN, MAX_STEPS=16, 4-bit increment network init 0 -> res_timeout=1, res_detect=16.
//  6 Two back-to-back inits (ring 0001, identity 0000) -> 2nd accepted 1 cycle after res handshake, both correct.

Source files
------------

// File: rtl/gnr_ctrl_pkg.sv
// Shared types and helpers for the GNR attractor controller.
// FSM state encoding, default counter width and a saturating increment.
package gnr_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_FIND,
      S_PERIOD,
      S_DONE
   } gnr_state_e;

   localparam int GNR_CNT_W = 32;

   // Counters stick at their maximum instead of wrapping back to zero.
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max_v);
      return (v >= max_v) ? v : v + 64'd1;
   endfunction

endpackage

// File: rtl/gnr_state_cmp.sv
// Wide equality compare of the slow and fast node-array state vectors.
module gnr_state_cmp #(
   parameter int N_NODES = 188
) (
   input  logic [N_NODES-1:0] net_s0,
   input  logic [N_NODES-1:0] net_s1,
   output logic               states_eq
);

   assign states_eq = (net_s0 == net_s1);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer for a GNR node array (load, find, period, done).
// Optional step budget enabled by defining GNR_TIMEOUT_EN.
module gnr_attractor_ctrl
   import gnr_ctrl_pkg::*;
#(
   parameter int N_NODES   = 188,
   parameter int CNT_W     = GNR_CNT_W,
   parameter int MAX_STEPS = 2**20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               init_valid,
   output logic               init_ready,
   input  logic [N_NODES-1:0] init_data,
   output logic               reset_nos,
   output logic [N_NODES-1:0] init_state,
   output logic               start_s0,
   output logic               start_s1,
   input  logic [N_NODES-1:0] net_s0,
   input  logic [N_NODES-1:0] net_s1,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [CNT_W-1:0]   res_detect,
   output logic [CNT_W-1:0]   res_period,
   output logic [N_NODES-1:0] res_state,
   output logic               res_timeout,
   output logic               busy
);

   localparam logic [63:0] CNT_MAX = (CNT_W >= 64) ? {64{1'b1}} : ((64'd1 << CNT_W) - 64'd1);

   gnr_state_e         state_q, state_d;
   logic [N_NODES-1:0] data_q, data_d;
   logic [CNT_W-1:0]   steps_q, steps_d;
   logic [CNT_W-1:0]   per_q, per_d;
   logic [CNT_W-1:0]   det_q, det_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [N_NODES-1:0] rstate_q, rstate_d;
   logic               states_eq;

   gnr_state_cmp #(.N_NODES(N_NODES)) u_cmp (
      .net_s0    (net_s0),
      .net_s1    (net_s1),
      .states_eq (states_eq)
   );

`ifdef GNR_TIMEOUT_EN
   localparam logic [CNT_W:0] BUDGET = (CNT_W+1)'(MAX_STEPS);
   logic             tout_q, tout_d;
   logic [CNT_W:0]   total_pulses;
   logic             budget_hit;
   assign total_pulses = {1'b0, steps_q} + {1'b0, per_q};
   assign budget_hit   = (total_pulses >= BUDGET);
   assign res_timeout  = tout_q;
`else
   assign res_timeout  = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         data_q   <= '0;
         steps_q  <= '0;
         per_q    <= '0;
         det_q    <= '0;
         period_q <= '0;
         rstate_q <= '0;
`ifdef GNR_TIMEOUT_EN
         tout_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         data_q   <= data_d;
         steps_q  <= steps_d;
         per_q    <= per_d;
         det_q    <= det_d;
         period_q <= period_d;
         rstate_q <= rstate_d;
`ifdef GNR_TIMEOUT_EN
         tout_q   <= tout_d;
`endif
      end
   end

   // The match decision and the start pulses come from the same cycle's compare.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      steps_d    = steps_q;
      per_d      = per_q;
      det_d      = det_q;
      period_d   = period_q;
      rstate_d   = rstate_q;
`ifdef GNR_TIMEOUT_EN
      tout_d     = tout_q;
`endif
      init_ready = 1'b0;
      reset_nos  = 1'b0;
      init_state = '0;
      start_s0   = 1'b0;
      start_s1   = 1'b0;
      res_valid  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            init_ready = 1'b1;
            if (init_valid) begin
               data_d  = init_data;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            reset_nos  = 1'b1;
            init_state = data_q;
            steps_d    = '0;
            per_d      = '0;
`ifdef GNR_TIMEOUT_EN
            tout_d     = 1'b0;
`endif
            state_d    = S_FIND;
         end
         S_FIND: begin
            if (!steps_q[0] && (|steps_q[CNT_W-1:1]) && states_eq) begin
               det_d   = steps_q;
               per_d   = '0;
               state_d = S_PERIOD;
            end
`ifdef GNR_TIMEOUT_EN
            else if (budget_hit) begin
               det_d    = steps_q;
               period_d = '0;
               rstate_d = net_s1;
               tout_d   = 1'b1;
               state_d  = S_DONE;
            end
`endif
            else begin
               start_s0 = 1'b1;
               start_s1 = 1'b1;
               steps_d  = CNT_W'(sat_inc(64'(steps_q), CNT_MAX));
            end
         end
         S_PERIOD: begin
            if ((|per_q) && states_eq) begin
               period_d = per_q;
               rstate_d = net_s1;
               state_d  = S_DONE;
            end
`ifdef GNR_TIMEOUT_EN
            else if (budget_hit) begin
               det_d    = steps_q;
               period_d = '0;
               rstate_d = net_s1;
               tout_d   = 1'b1;
               state_d  = S_DONE;
            end
`endif
            else begin
               start_s1 = 1'b1;
               per_d    = CNT_W'(sat_inc(64'(per_q), CNT_MAX));
            end
         end
         S_DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy       = (state_q != S_IDLE);
   assign res_detect = det_q;
   assign res_period = period_q;
   assign res_state  = rstate_q;

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench for gnr_attractor_ctrl with a 4-node behavioural network model.
// Network modes: 0 identity, 1 rotate-left ring, 2 four-bit increment.
module tb_gnr_attractor_ctrl;

   localparam int N  = 4;
   localparam int CW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          init_valid;
   logic          init_ready;
   logic [N-1:0]  init_data;
   logic          reset_nos;
   logic [N-1:0]  init_state;
   logic          start_s0;
   logic          start_s1;
   logic [N-1:0]  net_s0;
   logic [N-1:0]  net_s1;
   logic          res_valid;
   logic          res_ready;
   logic [CW-1:0] res_detect;
   logic [CW-1:0] res_period;
   logic [N-1:0]  res_state;
   logic          res_timeout;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int mode   = 0;

   gnr_attractor_ctrl #(.N_NODES(N), .CNT_W(CW), .MAX_STEPS(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .init_valid  (init_valid),
      .init_ready  (init_ready),
      .init_data   (init_data),
      .reset_nos   (reset_nos),
      .init_state  (init_state),
      .start_s0    (start_s0),
      .start_s1    (start_s1),
      .net_s0      (net_s0),
      .net_s1      (net_s1),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_detect  (res_detect),
      .res_period  (res_period),
      .res_state   (res_state),
      .res_timeout (res_timeout),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Node array model: s1 steps on every start_s1, s0 steps on every other start_s0.
   logic [N-1:0] s0_r = '0;
   logic [N-1:0] s1_r = '0;
   logic         tog_r = 1'b0;

   function automatic logic [N-1:0] step_fn(input logic [N-1:0] x, input int m);
      case (m)
         0:       return x;
         1:       return {x[N-2:0], x[N-1]};
         default: return x + 4'd1;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset_nos) begin
         s0_r  <= init_state;
         s1_r  <= init_state;
         tog_r <= 1'b0;
      end else begin
         if (start_s1) s1_r <= step_fn(s1_r, mode);
         if (start_s0) begin
            if (!tog_r) s0_r <= step_fn(s0_r, mode);
            tog_r <= ~tog_r;
         end
      end
   end

   assign net_s0 = s0_r;
   assign net_s1 = s1_r;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Offer an initial state from a negedge and confirm the one-cycle load pulse.
   task automatic applyStimulus(input logic [N-1:0] data, input int m);
      int n;
      mode       = m;
      init_data  = data;
      init_valid = 1'b1;
      n = 0;
      while (!init_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      init_valid = 1'b0;
      checkOutput("load_pulse", 64'(reset_nos), 64'(1));
      checkOutput("load_state", 64'(init_state), 64'(data));
      checkOutput("load_busy", 64'(busy), 64'(1));
   endtask

   // Wait for the result, then check it stays put for hold extra cycles.
   task automatic waitResult(input int det, input int per, input logic [N-1:0] st,
                             input logic tout, input int hold);
      int n;
      n = 0;
      while (!res_valid && n < 500) begin
         @(negedge clk);
         n++;
      end
      checkOutput("res_valid_wait", 64'(res_valid), 64'(1));
      checkOutput("res_detect", 64'(res_detect), 64'(det));
      checkOutput("res_period", 64'(res_period), 64'(per));
      checkOutput("res_state", 64'(res_state), 64'(st));
      checkOutput("res_timeout", 64'(res_timeout), 64'(tout));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", 64'(res_valid), 64'(1));
         checkOutput("hold_ready", 64'(init_ready), 64'(0));
         checkOutput("hold_detect", 64'(res_detect), 64'(det));
         checkOutput("hold_period", 64'(res_period), 64'(per));
         checkOutput("hold_state", 64'(res_state), 64'(st));
      end
   endtask

   task automatic releaseResult();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checkOutput("idle_valid", 64'(res_valid), 64'(0));
      checkOutput("idle_ready", 64'(init_ready), 64'(1));
   endtask

   initial begin
      rst        = 1'b1;
      init_valid = 1'b0;
      init_data  = '0;
      res_ready  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_init_ready", 64'(init_ready), 64'(1));
      checkOutput("rst_busy", 64'(busy), 64'(0));
      checkOutput("rst_res_valid", 64'(res_valid), 64'(0));
      checkOutput("rst_starts", 64'({reset_nos, start_s0, start_s1}), 64'(0));
      checkOutput("rst_res_detect", 64'(res_detect), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Identity network settles immediately: detect at the first legal step.
      applyStimulus(4'b0000, 0);
      waitResult(2, 1, 4'b0000, 1'b0, 0);
      releaseResult();

      // Ring of four: meet at k=8, period 4; results held while res_ready stays low.
      applyStimulus(4'b0001, 1);
      waitResult(8, 4, 4'b0001, 1'b0, 10);
      releaseResult();

      // Asynchronous reset in the middle of FIND at step 5.
      applyStimulus(4'b0001, 1);
      repeat (6) @(negedge clk);
      checkOutput("find_start_s1", 64'(start_s1), 64'(1));
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_starts", 64'({reset_nos, start_s0, start_s1}), 64'(0));
      checkOutput("arst_busy", 64'(busy), 64'(0));
      checkOutput("arst_init_ready", 64'(init_ready), 64'(1));
      checkOutput("arst_res", 64'({res_valid, res_detect, res_period}), 64'(0));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_ready", 64'(init_ready), 64'(1));
      applyStimulus(4'b0001, 1);
      waitResult(8, 4, 4'b0001, 1'b0, 0);
      releaseResult();

      // Increment network: budget abort at 16 pulses, or full detection without a budget.
      applyStimulus(4'b0000, 2);
`ifdef GNR_TIMEOUT_EN
      waitResult(16, 0, 4'b0000, 1'b1, 0);
`else
      waitResult(32, 16, 4'b0000, 1'b0, 0);
`endif
      releaseResult();

      // Back-to-back: second init held valid through the first handshake.
      applyStimulus(4'b0001, 1);
      waitResult(8, 4, 4'b0001, 1'b0, 0);
      init_data  = 4'b0000;
      init_valid = 1'b1;
      mode       = 0;
      releaseResult();
      applyStimulus(4'b0000, 0);
      waitResult(2, 1, 4'b0000, 1'b0, 0);
      releaseResult();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
